avalon_burst_slave: RTL and testbench

AVALON_BURST_SLAVE -- requirements
Module: avalon_burst_slave

---
 rtl/avalon_burst_slave.sv | 269 ++++++++++++++++++++++++++
 tb/tb_avalon_burst_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_slave.sv
`default_nettype none
// ============================================================================
// Module   : avalon_burst_slave
// Purpose  : Avalon-MM burst slave that fronts a small accelerator. It routes
//            word-addressed bursts to a CSR block, a weight memory, a pixel
//            memory and a read-only result memory. The memories are external
//            and have a 1-cycle read latency.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   read, write         : Avalon commands (write also marks a valid beat)
//   beginbursttransfer  : first cycle of a burst
//   burstcount          : beats in burst (0 treated as 1)
//   address, writedata  : word address / write beat data
//   readdata            : read beat data (zero-extended)
//   readdatavalid       : read beat valid
//   writeresponsevalid  : write burst response valid
//   response            : 00 OKAY, 10 SLAVEERROR, 11 DECODEERROR
//   waitrequest         : command/beat not accepted
//   mem_addr, mem_wdata : shared memory offset / write data
//   mem_we              : bit0 weight memory, bit1 pixel memory
//   weight_rdata, pixel_rdata, result_rdata : memory read data
//   done_calc           : calculation-complete pulse
//   start_calc          : one-cycle start pulse
// ============================================================================
module avalon_burst_slave #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 11,
  parameter int BURST_W = 10,
  parameter int STORE_W = 16,
  parameter int RES_W   = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic                write,
  input  logic                beginbursttransfer,
  input  logic [BURST_W-1:0]  burstcount,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                writeresponsevalid,
  output logic [1:0]          response,
  output logic                waitrequest,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [STORE_W-1:0]  mem_wdata,
  output logic [1:0]          mem_we,
  input  logic [STORE_W-1:0]  weight_rdata,
  input  logic [STORE_W-1:0]  pixel_rdata,
  input  logic [RES_W-1:0]    result_rdata,
  input  logic                done_calc,
  output logic                start_calc
);

  localparam int OFF_W = ADDR_W - 2;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  localparam logic [1:0] c_reg_csr = 2'b00;
  localparam logic [1:0] c_reg_wgt = 2'b01;
  localparam logic [1:0] c_reg_pix = 2'b10;
  localparam logic [1:0] c_reg_res = 2'b11;

  localparam logic [OFF_W-1:0]   c_off_ctrl   = '0;
  localparam logic [OFF_W-1:0]   c_off_status = OFF_W'(1);
  localparam logic [BURST_W-1:0] c_one_beat   = BURST_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_BURST = 2'd2,
    S_RD_DRAIN = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic [OFF_W-1:0]   r_offset;
  logic [1:0]         r_region;
  logic [BURST_W-1:0] r_remaining;
  logic [1:0]         r_werr;
  logic               r_s1_valid;
  logic [1:0]         r_s1_region;
  logic [1:0]         r_s1_resp;
  logic [1:0]         r_s1_csr;
  logic               r_done, r_busy, r_start;
  logic               r_rdv, r_wrv;
  logic [DATA_W-1:0]  r_rdata;
  logic [1:0]         r_resp;

  logic               w_wr_accept, w_rd_accept, w_rd_issue, w_last_beat;
  logic               w_waitrequest;
  logic [OFF_W-1:0]   w_beat_offset;
  logic [1:0]         w_beat_region;
  logic [1:0]         w_beat_err;
  logic [1:0]         w_wresp;
  logic [BURST_W-1:0] w_burst_len;
  logic               w_ctrl_wr, w_start, w_clr;
  logic [DATA_W-1:0]  w_rd_mux;
  logic               w_unused;

  // Without beginbursttransfer the command is a single beat.
  assign w_burst_len = (!beginbursttransfer || burstcount == '0) ? c_one_beat : burstcount;

  // Next-state and handshake decode.
  always_comb begin
    w_state_next  = r_state;
    w_waitrequest = 1'b0;
    w_wr_accept   = 1'b0;
    w_rd_accept   = 1'b0;
    w_rd_issue    = 1'b0;
    w_last_beat   = 1'b0;
    w_beat_offset = r_offset;
    w_beat_region = r_region;
    unique case (r_state)
      S_IDLE: begin
        // The first beat is served straight from the command bus.
        w_beat_offset = address[OFF_W-1:0];
        w_beat_region = address[ADDR_W-1 -: 2];
        if (write) begin
          w_wr_accept = 1'b1;
          if (w_burst_len == c_one_beat) w_last_beat = 1'b1;
          else                           w_state_next = S_WR_BURST;
        end else if (read) begin
          w_rd_accept  = 1'b1;
          w_state_next = S_RD_BURST;
        end
      end
      S_WR_BURST: begin
        if (write) begin
          w_wr_accept = 1'b1;
          if (r_remaining == c_one_beat) begin
            w_last_beat  = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_RD_BURST: begin
        w_waitrequest = 1'b1;
        w_rd_issue    = 1'b1;
        if (r_remaining == c_one_beat) w_state_next = S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        w_waitrequest = 1'b1;
        // The beat in the output stage now is the last one.
        if (!r_s1_valid) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (rst) begin
      w_waitrequest = 1'b1;
      w_wr_accept   = 1'b0;
      w_rd_accept   = 1'b0;
      w_rd_issue    = 1'b0;
      w_last_beat   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Per-beat error classification (reads and writes share the decode).
  always_comb begin
    w_beat_err = c_resp_okay;
    if (w_beat_region == c_reg_csr && w_beat_offset > c_off_status)
      w_beat_err = c_resp_decerr;
    else if (w_beat_region == c_reg_res && !w_rd_issue)
      w_beat_err = c_resp_slverr;
  end

  // Worst-case accumulation: the encodings order numerically by severity.
  always_comb begin
    w_wresp = w_beat_err;
    if (r_state != S_IDLE && r_werr > w_beat_err) w_wresp = r_werr;
  end

  assign w_ctrl_wr = w_wr_accept && w_beat_region == c_reg_csr && w_beat_offset == c_off_ctrl;
  assign w_start   = w_ctrl_wr && writedata[0];
  assign w_clr     = w_ctrl_wr && writedata[1];

  always_comb begin
    w_rd_mux = '0;
    if (r_s1_valid && r_s1_resp == c_resp_okay) begin
      unique case (r_s1_region)
        c_reg_csr: w_rd_mux = DATA_W'(r_s1_csr);
        c_reg_wgt: w_rd_mux = DATA_W'(weight_rdata);
        c_reg_pix: w_rd_mux = DATA_W'(pixel_rdata);
        c_reg_res: w_rd_mux = DATA_W'(result_rdata);
        default:   w_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset    <= '0;
      r_region    <= '0;
      r_remaining <= '0;
      r_werr      <= c_resp_okay;
      r_s1_valid  <= 1'b0;
      r_s1_region <= '0;
      r_s1_resp   <= c_resp_okay;
      r_s1_csr    <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_rdv       <= 1'b0;
      r_wrv       <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= c_resp_okay;
    end else begin
      r_start <= w_start;
      // done_calc wins over a clear in the same cycle.
      if (done_calc)               r_done <= 1'b1;
      else if (w_clr || w_start)   r_done <= 1'b0;
      if (done_calc)               r_busy <= 1'b0;
      else if (w_start)            r_busy <= 1'b1;

      if (w_wr_accept) begin
        r_werr   <= w_wresp;
        r_offset <= w_beat_offset + 1'b1;
        r_region <= w_beat_region;
        if (r_state == S_IDLE) r_remaining <= w_burst_len - 1'b1;
        else                   r_remaining <= r_remaining - 1'b1;
      end else if (w_rd_accept) begin
        r_offset    <= address[OFF_W-1:0];
        r_region    <= address[ADDR_W-1 -: 2];
        r_remaining <= w_burst_len;
      end else if (w_rd_issue) begin
        r_offset    <= r_offset + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end

      // Stage 1: the memory is fetching the issued offset.
      r_s1_valid  <= w_rd_issue;
      r_s1_region <= r_region;
      r_s1_resp   <= w_beat_err;
      r_s1_csr    <= (r_offset == c_off_status) ? {r_busy, r_done} : 2'b00;

      // Stage 2: response registers.
      r_rdv   <= r_s1_valid;
      r_wrv   <= w_last_beat;
      r_rdata <= w_rd_mux;
      if (w_last_beat)     r_resp <= w_wresp;
      else if (r_s1_valid) r_resp <= r_s1_resp;
      else                 r_resp <= c_resp_okay;
    end
  end

  assign waitrequest        = w_waitrequest;
  assign readdata           = r_rdata;
  assign readdatavalid      = r_rdv;
  assign writeresponsevalid = r_wrv;
  assign response           = r_resp;
  assign start_calc         = r_start;
  assign mem_addr           = rst ? '0 : w_beat_offset;
  assign mem_wdata          = rst ? '0 : writedata[STORE_W-1:0];
  assign mem_we             = (w_wr_accept && w_beat_region == c_reg_wgt) ? 2'b01 :
                              (w_wr_accept && w_beat_region == c_reg_pix) ? 2'b10 : 2'b00;

  assign w_unused = ^writedata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_burst_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_burst_slave
// Purpose  : Directed self-checking bench for avalon_burst_slave. Models the
//            three 1-cycle-latency memories with offset-derived contents.
// Revision : 1.0  initial release
// ============================================================================
module tb_avalon_burst_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write, beginbursttransfer, done_calc;
  logic [9:0]  burstcount;
  logic [10:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid, writeresponsevalid, waitrequest, start_calc;
  logic [1:0]  response, mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata, weight_rdata, pixel_rdata;
  logic [16:0] result_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_burst_slave dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
    .address(address), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .writeresponsevalid(writeresponsevalid),
    .response(response), .waitrequest(waitrequest), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .weight_rdata(weight_rdata),
    .pixel_rdata(pixel_rdata), .result_rdata(result_rdata),
    .done_calc(done_calc), .start_calc(start_calc)
  );

  // Memory model: contents are a function of the offset.
  always @(posedge clk) begin
    weight_rdata <= 16'(mem_addr);
    pixel_rdata  <= 16'h5000 | 16'(mem_addr);
    result_rdata <= 17'h10000 | 17'(mem_addr);
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic single_write(input logic [10:0] a, input logic [31:0] wd,
                              output logic [1:0] we, output logic wrv, output logic [1:0] r);
    next(); write = 1'b1; address = a; writedata = wd; beginbursttransfer = 1'b1; burstcount = 10'd1;
    settle(); we = mem_we;
    next(); write = 1'b0; beginbursttransfer = 1'b0;
    settle(); wrv = writeresponsevalid; r = response;
  endtask

  task automatic single_read(input logic [10:0] a, output logic [31:0] d,
                             output logic [1:0] r, output int lat);
    lat = -1; d = '0; r = '0;
    next(); read = 1'b1; address = a; beginbursttransfer = 1'b1; burstcount = 10'd1;
    next(); read = 1'b0; beginbursttransfer = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      settle();
      if (readdatavalid && lat < 0) begin lat = j; d = readdata; r = response; end
      next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r, we;
    logic        wrv;
    int          lat;
    logic [31:0] exp_rd [4];
    logic [8:0]  exp_iss [4];
    exp_rd  = '{32'h1FE, 32'h1FF, 32'h0, 32'h1};
    exp_iss = '{9'h1FE, 9'h1FF, 9'h0, 9'h1};

    rst = 1'b1; read = 0; write = 0; beginbursttransfer = 0; done_calc = 0;
    burstcount = '0; address = '0; writedata = '0;
    repeat (3) next();
    settle();
    check("rst_waitrequest", 32'(waitrequest), 32'd1);
    check("rst_outputs", {readdatavalid, writeresponsevalid, start_calc, mem_we, response}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    next(); rst = 1'b0; settle();
    check("rst_release_waitrequest", 32'(waitrequest), 32'd0);

    // Single write to weights offset 1, with read also high (write wins).
    next(); write = 1; read = 1; address = 11'h201; writedata = 32'h8; beginbursttransfer = 1; burstcount = 10'd1;
    settle();
    check("sw_mem_we", 32'(mem_we), 32'h1);
    check("sw_mem_addr", 32'(mem_addr), 32'h1);
    check("sw_mem_wdata", 32'(mem_wdata), 32'h8);
    next(); write = 0; read = 0; beginbursttransfer = 0; settle();
    check("sw_wrv", 32'(writeresponsevalid), 32'd1);
    check("sw_resp", 32'(response), 32'd0);
    check("sw_no_read", 32'(waitrequest), 32'd0);
    next(); settle();
    check("sw_wrv_pulse", 32'(writeresponsevalid), 32'd0);

    // 10-beat pixel burst.
    next(); write = 1; beginbursttransfer = 1; burstcount = 10'd10; address = 11'h400;
    for (int i = 0; i < 10; i++) begin
      writedata = 32'(2 * i);
      if (i > 0) beginbursttransfer = 0;
      settle();
      check("bw_mem_we", 32'(mem_we), 32'h2);
      check("bw_mem_addr", 32'(mem_addr), 32'(i));
      check("bw_mem_wdata", 32'(mem_wdata), 32'(2 * i));
      check("bw_no_wrv", 32'(writeresponsevalid), 32'd0);
      next();
    end
    write = 0; settle();
    check("bw_wrv", 32'(writeresponsevalid), 32'd1);
    check("bw_resp", 32'(response), 32'd0);
    check("bw_idle_we", 32'(mem_we), 32'd0);
    next(); settle();
    check("bw_wrv_pulse", 32'(writeresponsevalid), 32'd0);

    // 3-beat pixel burst with a stall cycle.
    next(); write = 1; beginbursttransfer = 1; burstcount = 10'd3; address = 11'h410; writedata = 32'h11;
    settle(); check("st_b0_addr", 32'(mem_addr), 32'h10);
    next(); beginbursttransfer = 0; writedata = 32'h22;
    settle(); check("st_b1_we", 32'(mem_we), 32'h2); check("st_b1_addr", 32'(mem_addr), 32'h11);
    next(); write = 0;
    settle(); check("st_stall_we", 32'(mem_we), 32'd0); check("st_stall_wrv", 32'(writeresponsevalid), 32'd0);
    next(); write = 1; writedata = 32'h33;
    settle(); check("st_b2_we", 32'(mem_we), 32'h2); check("st_b2_addr", 32'(mem_addr), 32'h12);
    check("st_b2_wdata", 32'(mem_wdata), 32'h33);
    next(); write = 0;
    settle(); check("st_wrv", 32'(writeresponsevalid), 32'd1); check("st_resp", 32'(response), 32'd0);

    // 4-beat read at 0x3FE, wraps within the weight region.
    next(); read = 1; beginbursttransfer = 1; burstcount = 10'd4; address = 11'h3FE;
    settle(); check("br_accept_wait", 32'(waitrequest), 32'd0);
    next(); read = 0; beginbursttransfer = 0;
    for (int j = 1; j <= 7; j++) begin
      settle();
      check("br_waitrequest", 32'(waitrequest), (j <= 6) ? 32'd1 : 32'd0);
      check("br_rdv", 32'(readdatavalid), (j >= 3 && j <= 6) ? 32'd1 : 32'd0);
      check("br_readdata", readdata, (j >= 3 && j <= 6) ? exp_rd[j-3] : 32'd0);
      check("br_resp", 32'(response), 32'd0);
      if (j <= 4) check("br_issue_addr", 32'(mem_addr), 32'(exp_iss[j-1]));
      next();
    end

    // CSR: start, status, done, clear.
    next(); write = 1; address = 11'h000; writedata = 32'h1; beginbursttransfer = 1; burstcount = 10'd1;
    settle(); check("csr_start_early", 32'(start_calc), 32'd0);
    next(); write = 0; beginbursttransfer = 0;
    settle(); check("csr_start_pulse", 32'(start_calc), 32'd1); check("csr_ctrl_resp", {30'd0, response}, 32'd0);
    next(); settle(); check("csr_start_once", 32'(start_calc), 32'd0);
    single_read(11'h001, d, r, lat);
    check("status_busy", d, 32'h2); check("status_busy_lat", 32'(lat), 32'd3); check("status_busy_resp", 32'(r), 32'd0);
    next(); done_calc = 1; next(); done_calc = 0;
    single_read(11'h001, d, r, lat);
    check("status_done", d, 32'h1);
    single_write(11'h000, 32'h2, we, wrv, r);
    check("ctrl_clr_wrv", 32'(wrv), 32'd1);
    single_read(11'h001, d, r, lat);
    check("status_cleared", d, 32'h0);
    single_read(11'h000, d, r, lat);
    check("ctrl_read_zero", d, 32'h0); check("ctrl_read_resp", 32'(r), 32'd0);
    // done_calc in the same cycle as a clear leaves done set.
    next(); write = 1; address = 11'h000; writedata = 32'h2; beginbursttransfer = 1; burstcount = 10'd1; done_calc = 1;
    next(); write = 0; beginbursttransfer = 0; done_calc = 0;
    single_read(11'h001, d, r, lat);
    check("status_done_wins", d, 32'h1);

    // Error paths and result region.
    single_write(11'h600, 32'h5, we, wrv, r);
    check("res_wr_we", 32'(we), 32'd0); check("res_wr_wrv", 32'(wrv), 32'd1); check("res_wr_resp", 32'(r), 32'h2);
    single_read(11'h005, d, r, lat);
    check("csr5_data", d, 32'd0); check("csr5_resp", 32'(r), 32'h3); check("csr5_lat", 32'(lat), 32'd3);
    single_read(11'h603, d, r, lat);
    check("res_rd_data", d, 32'h10003); check("res_rd_resp", 32'(r), 32'd0);
    single_read(11'h405, d, r, lat);
    check("pix_rd_data", d, 32'h5005);
    // Two-beat CSR burst: STATUS (ok) then offset 2 (decode) -> worst case.
    next(); write = 1; address = 11'h001; writedata = 32'h0; beginbursttransfer = 1; burstcount = 10'd2;
    next(); beginbursttransfer = 0;
    next(); write = 0; settle();
    check("csr_burst_wrv", 32'(writeresponsevalid), 32'd1); check("csr_burst_resp", 32'(response), 32'h3);

    // Reset in the middle of a 10-beat weight burst.
    next(); write = 1; beginbursttransfer = 1; burstcount = 10'd10; address = 11'h200;
    for (int i = 0; i < 3; i++) begin
      writedata = 32'(i); if (i > 0) beginbursttransfer = 0;
      settle(); check("rb_mem_we", 32'(mem_we), 32'h1);
      next();
    end
    rst = 1; settle();
    check("rb_rst_we", 32'(mem_we), 32'd0); check("rb_rst_wait", 32'(waitrequest), 32'd1);
    next(); settle(); check("rb_rst_we2", 32'(mem_we), 32'd0);
    next(); rst = 0; write = 0; settle();
    check("rb_release_wait", 32'(waitrequest), 32'd0);
    for (int j = 0; j < 4; j++) begin
      check("rb_quiet", {mem_we, writeresponsevalid, readdatavalid}, 32'd0);
      next(); settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
